// File: rtl/axird_batch_sched.sv
// axird_batch_sched: job sequencer for the AXI read datapath (KSK load and
// preprocess input streaming). It accepts a KSK-init or an N-batch run job and
// drives the datapath command/initstart/start controls. Each batch after the
// first is gated on a free preprocess-buffer slot (credit).
// Optional build macro: AXIRD_SCHED_WATCHDOG_EN adds a WDOG_W-bit watchdog on
// the states that wait for the datapath. On expiry it raises a sticky error
// and abandons the job.
module axird_batch_sched #(
  parameter int BATCH_W    = 15,
  parameter int CREDIT_MAX = 2,
  parameter int WDOG_W     = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_sched_start,
  input  logic               i_sched_mode,
  input  logic [BATCH_W-1:0] i_sched_batches,
  output logic               o_sched_busy,
  output logic               o_sched_done,
  output logic               o_sched_err,
  output logic [31:0]        o_axird_command,
  output logic               o_axird_initstart,
  output logic               o_axird_start,
  input  logic               i_axird_done,
  input  logic               i_axird_alldone,
  input  logic               i_pre_release,
  output logic [BATCH_W-1:0] o_batch_idx,
  output logic               o_batch_valid
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KSK   = 3'd1,
    S_LOAD  = 3'd2,
    S_GAP   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam logic [2:0]         CMAX  = 3'(CREDIT_MAX);
  localparam logic [BATCH_W-1:0] B_ONE = BATCH_W'(1);

  state_t             r_state, w_state_nxt;
  logic               r_mode, w_mode_nxt;
  logic [BATCH_W-1:0] r_n, w_n_nxt;
  logic [BATCH_W-1:0] r_idx, w_idx_nxt;
  logic [BATCH_W-1:0] r_bidx, w_bidx_nxt;
  logic [2:0]         r_credit, w_credit_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic               r_err, w_err_nxt;
  logic               r_initstart, w_initstart_nxt;
  logic               r_start, w_start_nxt;
  logic               r_valid, w_valid_nxt;

  logic w_blank, w_done_s, w_alldone_s, w_last, w_issue, w_rel, w_wdog_hit;

  // Datapath status is blanked in the cycle a start pulse is on the wire.
  assign w_blank     = r_initstart | r_start;
  assign w_done_s    = i_axird_done & ~w_blank;
  assign w_alldone_s = i_axird_alldone & ~w_blank;
  assign w_last      = (r_idx == (r_n - B_ONE));
  assign w_issue     = (r_state == S_GAP) && (r_credit != 3'd0);
  assign w_rel       = i_pre_release && (r_state != S_IDLE);

`ifdef AXIRD_SCHED_WATCHDOG_EN
  logic [WDOG_W-1:0] r_wdog;
  logic              w_wait_state;

  assign w_wait_state = (r_state == S_KSK) || (r_state == S_LOAD) || (r_state == S_DRAIN);
  assign w_wdog_hit   = (&r_wdog) && w_wait_state;

  // Watchdog: restarts on every state change and counts while waiting on the datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog <= {WDOG_W{1'b0}};
    end else if (w_state_nxt != r_state) begin
      r_wdog <= {WDOG_W{1'b0}};
    end else if (w_wait_state) begin
      r_wdog <= r_wdog + WDOG_W'(1);
    end else begin
      r_wdog <= {WDOG_W{1'b0}};
    end
  end
`else
  // No watchdog built: it can never expire (WDOG_W is always at least 1).
  assign w_wdog_hit = (WDOG_W < 1);
`endif

  // State and registered-output update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mode      <= 1'b0;
      r_n         <= {BATCH_W{1'b0}};
      r_idx       <= {BATCH_W{1'b0}};
      r_bidx      <= {BATCH_W{1'b0}};
      r_credit    <= CMAX;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_initstart <= 1'b0;
      r_start     <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mode      <= w_mode_nxt;
      r_n         <= w_n_nxt;
      r_idx       <= w_idx_nxt;
      r_bidx      <= w_bidx_nxt;
      r_credit    <= w_credit_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_initstart <= w_initstart_nxt;
      r_start     <= w_start_nxt;
      r_valid     <= w_valid_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_sched_start && !i_sched_mode) w_state_nxt = S_KSK;
        else if (i_sched_start && (i_sched_batches != {BATCH_W{1'b0}})) w_state_nxt = S_LOAD;
        else w_state_nxt = S_IDLE;
      end
      S_KSK, S_DRAIN: begin
        if (w_alldone_s || w_wdog_hit) w_state_nxt = S_IDLE;
        else w_state_nxt = r_state;
      end
      S_LOAD: begin
        if (w_done_s) w_state_nxt = w_last ? S_DRAIN : S_GAP;
        else if (w_wdog_hit) w_state_nxt = S_IDLE;
        else w_state_nxt = S_LOAD;
      end
      S_GAP: begin
        if (w_issue) w_state_nxt = S_LOAD;
        else w_state_nxt = S_GAP;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output pulses, job registers and credit bookkeeping.
  always_comb begin
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_done_nxt      = 1'b0;
    w_initstart_nxt = 1'b0;
    w_start_nxt     = 1'b0;
    w_valid_nxt     = 1'b0;
    w_err_nxt       = r_err;
    w_mode_nxt      = r_mode;
    w_n_nxt         = r_n;
    w_idx_nxt       = r_idx;
    w_bidx_nxt      = r_bidx;
    // A release and an issued start in the same cycle cancel out.
    case ({w_rel, w_issue})
      2'b10:   w_credit_nxt = (r_credit >= CMAX) ? CMAX : (r_credit + 3'd1);
      2'b01:   w_credit_nxt = r_credit - 3'd1;
      default: w_credit_nxt = r_credit;
    endcase
    case (r_state)
      S_IDLE: begin
        if (i_sched_start) begin
          w_err_nxt = 1'b0;
          if (!i_sched_mode) begin
            w_mode_nxt      = 1'b0;
            w_initstart_nxt = 1'b1;
          end else if (i_sched_batches != {BATCH_W{1'b0}}) begin
            w_mode_nxt      = 1'b1;
            w_n_nxt         = i_sched_batches;
            w_credit_nxt    = CMAX - 3'd1;
            w_idx_nxt       = {BATCH_W{1'b0}};
            w_bidx_nxt      = {BATCH_W{1'b0}};
            w_initstart_nxt = 1'b1;
          end else begin
            w_done_nxt = 1'b1;
          end
        end else begin
          w_err_nxt = r_err;
        end
      end
      S_KSK, S_DRAIN: begin
        if (w_alldone_s) w_done_nxt = 1'b1;
        else if (w_wdog_hit) w_err_nxt = 1'b1;
        else w_done_nxt = 1'b0;
      end
      S_LOAD: begin
        if (w_done_s) begin
          w_valid_nxt = 1'b1;
          w_bidx_nxt  = r_idx;
          if (!w_last) w_idx_nxt = r_idx + B_ONE;
          else w_idx_nxt = r_idx;
        end else if (w_wdog_hit) begin
          w_err_nxt = 1'b1;
        end else begin
          w_valid_nxt = 1'b0;
        end
      end
      S_GAP: begin
        if (w_issue) begin
          w_start_nxt = 1'b1;
          w_bidx_nxt  = r_idx;
        end else begin
          w_start_nxt = 1'b0;
        end
      end
      default: w_done_nxt = 1'b0;
    endcase
  end

  assign o_sched_busy      = r_busy;
  assign o_sched_done      = r_done;
  assign o_sched_err       = r_err;
  assign o_axird_command   = {31'b0, r_mode};
  assign o_axird_initstart = r_initstart;
  assign o_axird_start     = r_start;
  assign o_batch_idx       = r_bidx;
  assign o_batch_valid     = r_valid;

endmodule
